fracnet_mul_share_arb: RTL and testbench

Round-robin arbiter and pipeline controller that time-shares one 16x16 unsigned-by-signed DSP multiplier among `NUM_REQ` requesters inside the FracNet compute core. Each requester presents operands with a valid/ready handshake. The block grants one requester per cycle, drives the multiplier through `MUL_STAGES` registered stages, and returns the 32-bit signed product tagged with the winning requester's ID and tag. The whole pipeline stalls as a unit under output backpressure, so no result is ever lost.

---
 rtl/fracnet_mul_share_arb_if.sv | 31 +++
 rtl/fracnet_mul_share_arb.sv | 185 ++++++++++++++++++
 tb/tb_fracnet_mul_share_arb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fracnet_mul_share_arb_if.sv
// Request/result bundle between the FracNet requesters, the result consumer and the
// shared-multiplier arbiter. The master side drives requests and result acceptance.
interface fracnet_mul_share_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*16-1:0]    req_a;
   logic [NUM_REQ*16-1:0]    req_b;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     res_valid;
   logic                     res_ready;
   logic [31:0]              res_p;
   logic [ID_W-1:0]          res_id;
   logic [TAG_W-1:0]         res_tag;
   logic                     busy;

   modport master (
      output req_valid, req_a, req_b, req_tag, res_ready,
      input  req_ready, res_valid, res_p, res_id, res_tag, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_tag, res_ready,
      output req_ready, res_valid, res_p, res_id, res_tag, busy
   );

endinterface

// File: rtl/fracnet_mul_share_arb.sv
// fracnet_mul_share_arb: round-robin time-sharing of one 16x16 unsigned-by-signed multiplier
// among NUM_REQ requesters. The pipeline advances as a single unit and freezes entirely while
// the result at the output is not accepted, so no result is ever dropped.
module fracnet_mul_share_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MUL_STAGES = 2,
   parameter int unsigned TAG_W      = 8,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input logic                    ap_clk,
   input logic                    ap_rst_n,
   fracnet_mul_share_arb_if.slave bus
);

   // Pipeline advance enable: only a held result at the output can stall.
   logic                 en;
   logic                 hs;

   // Round-robin pointer and combinational winner.
   logic [ID_W-1:0]      rr_q, rr_d;
   logic [NUM_REQ-1:0]   win;
   logic                 win_any;
   logic [ID_W-1:0]      win_id;
   logic [15:0]          win_a;
   logic [15:0]          win_b;
   logic [TAG_W-1:0]     win_tag;

   // Per-stage control: valid, requester id and tag travel alongside the data.
   logic [MUL_STAGES-1:0] vld_q;
   logic [ID_W-1:0]       id_q  [MUL_STAGES];
   logic [TAG_W-1:0]      tag_q [MUL_STAGES];

   // Multiplier operands and product.
   logic [15:0]          mul_a;
   logic [15:0]          mul_b;
   logic [31:0]          mul_p;
   logic [31:0]          res_p_w;

   assign en = !(vld_q[MUL_STAGES-1] && !bus.res_ready);

   // Search from rr_q upwards (mod NUM_REQ) for the first valid requester.
   always_comb begin
      logic [ID_W:0] idx;
      idx     = '0;
      win     = '0;
      win_any = 1'b0;
      win_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!win_any && bus.req_valid[idx[ID_W-1:0]]) begin
            win_any = 1'b1;
            win_id  = idx[ID_W-1:0];
         end
      end
      win[win_id] = win_any;
   end

   // Select the winning requester's operands and tag.
   always_comb begin
      win_a   = '0;
      win_b   = '0;
      win_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            win_a   = bus.req_a[16*i +: 16];
            win_b   = bus.req_b[16*i +: 16];
            win_tag = bus.req_tag[TAG_W*i +: TAG_W];
         end
      end
   end

   // Grants are masked during reset and while the output is stalled.
   assign bus.req_ready = (ap_rst_n && en) ? win : '0;
   assign hs            = ap_rst_n && en && win_any;

   // Pointer moves just past the requester that completed a handshake.
   always_comb begin
      rr_d = rr_q;
      if (hs) begin
         if (win_id == ID_W'(NUM_REQ - 1)) begin
            rr_d = '0;
         end else begin
            rr_d = win_id + ID_W'(1);
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Control shift register: a bubble enters stage 1 whenever no handshake occurs.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
         for (int s = 0; s < MUL_STAGES; s++) begin
            id_q[s]  <= '0;
            tag_q[s] <= '0;
         end
      end else if (en) begin
         vld_q[0] <= hs;
         id_q[0]  <= win_id;
         tag_q[0] <= win_tag;
         for (int s = 1; s < MUL_STAGES; s++) begin
            vld_q[s] <= vld_q[s-1];
            id_q[s]  <= id_q[s-1];
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // Operand a is unsigned, so widen it with a zero before the signed multiply.
   always_comb begin
      mul_p = $signed({16'h0000, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
   end

   if (MUL_STAGES == 1) begin : g_single
      logic [31:0] prod_q;

      assign mul_a = win_a;
      assign mul_b = win_b;

      // Single stage: product of the granted operands lands straight in the result register.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            prod_q <= '0;
         end else if (en) begin
            prod_q <= mul_p;
         end
      end

      assign res_p_w = prod_q;
   end else begin : g_multi
      logic [15:0] opa_q;
      logic [15:0] opb_q;
      logic [31:0] prod_q [MUL_STAGES-1];

      assign mul_a = opa_q;
      assign mul_b = opb_q;

      // Stage 1 holds operands; later stages carry the registered product.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
            for (int s = 0; s < MUL_STAGES - 1; s++) begin
               prod_q[s] <= '0;
            end
         end else if (en) begin
            opa_q     <= win_a;
            opb_q     <= win_b;
            prod_q[0] <= mul_p;
            for (int s = 1; s < MUL_STAGES - 1; s++) begin
               prod_q[s] <= prod_q[s-1];
            end
         end
      end

      assign res_p_w = prod_q[MUL_STAGES-2];
   end

   assign bus.res_valid = vld_q[MUL_STAGES-1];
   assign bus.res_p     = res_p_w;
   assign bus.res_id    = id_q[MUL_STAGES-1];
   assign bus.res_tag   = tag_q[MUL_STAGES-1];
   assign bus.busy      = |vld_q;

   // At most one requester is granted per cycle.
   a_grant_onehot: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      $onehot0(bus.req_ready));

   // A result waiting for the consumer keeps its payload.
   a_stall_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      bus.res_valid && !bus.res_ready |=> bus.res_valid && $stable(bus.res_p) &&
      $stable(bus.res_id) && $stable(bus.res_tag));

endmodule

// File: tb/tb_fracnet_mul_share_arb.sv
// Scoreboard bench for fracnet_mul_share_arb: a queue-based model of in-flight requests decides
// grants, output validity and expected products; a monitor pops and compares results.
module tb_fracnet_mul_share_arb;

   localparam int unsigned NR = 4;
   localparam int unsigned MS = 2;
   localparam int unsigned TW = 8;
   localparam int unsigned IW = 2;

   typedef struct packed {
      logic [31:0]   p;
      int            id;
      logic [TW-1:0] tag;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fracnet_mul_share_arb_if #(.NUM_REQ(NR), .TAG_W(TW), .ID_W(IW)) bus ();

   fracnet_mul_share_arb #(
      .NUM_REQ    (NR),
      .MUL_STAGES (MS),
      .TAG_W      (TW),
      .ID_W       (IW)
   ) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (bus)
   );

   int            checks = 0;
   int            errors = 0;
   // Model state: ages of in-flight entries (oldest first), pointer, expected results.
   int            ages[$];
   res_t          sb[$];
   int            rr = 0;
   int            dut_grants[$];
   // Requester state.
   logic [NR-1:0] pend;
   logic [15:0]   pa [NR];
   logic [15:0]   pb [NR];
   logic [TW-1:0] pt [NR];
   logic          rdy;
   logic          rst_cmd;
   int            mode;
   int            fair_cnt;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endfunction

   task automatic chk_grant(string nm, int k, int exp);
      if (dut_grants.size() > k) begin
         chk(nm, dut_grants[k], exp);
      end else begin
         checks++;
         errors++;
         $display("FAIL %s grant #%0d missing actual=none required=%0d", nm, k, exp);
      end
   endtask

   function automatic logic [15:0] rnd_op(bit is_b);
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return is_b ? 16'h8000 : 16'h0001;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic issue(int i, logic [15:0] a, logic [15:0] b, logic [TW-1:0] t);
      pend[i] = 1'b1;
      pa[i]   = a;
      pb[i]   = b;
      pt[i]   = t;
   endtask

   task automatic issue_rnd(int i);
      issue(i, rnd_op(1'b0), rnd_op(1'b1), TW'($urandom));
   endtask

   task automatic apply_policy();
      if (mode == 1) begin
         rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 40) issue_rnd(i);
            else if (pend[i] && $urandom_range(0, 99) < 5) pend[i] = 1'b0;
         end
      end else if (mode == 2) begin
         for (int i = 0; i < NR; i++) if (!pend[i]) issue_rnd(i);
      end else if (mode == 3) begin
         if (!pend[0]) issue_rnd(0);
         if (fair_cnt >= 5 && !pend[3]) issue_rnd(3);
         fair_cnt++;
      end
   endtask

   task automatic drive();
      logic [NR*16-1:0] va, vb;
      logic [NR*TW-1:0] vt;
      for (int i = 0; i < NR; i++) begin
         va[16*i +: 16] = pa[i];
         vb[16*i +: 16] = pb[i];
         vt[TW*i +: TW] = pt[i];
      end
      bus.req_valid = pend;
      bus.req_a     = va;
      bus.req_b     = vb;
      bus.req_tag   = vt;
      bus.res_ready = rdy;
   endtask

   // One clock cycle: drive after the rising edge, check and advance the model mid-cycle.
   task automatic step();
      logic [NR-1:0] exp_rdy;
      logic          exp_rv;
      logic          en;
      int            g;
      longint        pr;
      res_t          r;
      @(posedge clk);
      #1;
      if (rst_cmd != rst_n) begin
         rst_n = rst_cmd;
         if (!rst_cmd) begin
            ages.delete();
            sb.delete();
            dut_grants.delete();
            rr   = 0;
            pend = '0;
         end
      end
      apply_policy();
      drive();
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_res_valid", bus.res_valid, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_res_p", bus.res_p, 0);
         chk("rst_res_id", bus.res_id, 0);
         chk("rst_res_tag", bus.res_tag, 0);
         return;
      end
      exp_rv = (ages.size() > 0) && (ages[0] == MS);
      chk("res_valid", bus.res_valid, exp_rv);
      chk("busy", bus.busy, ages.size() != 0);
      en = !(exp_rv && !rdy);
      g  = -1;
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (rr + k) % NR;
         if (g < 0 && pend[i]) g = i;
      end
      exp_rdy = '0;
      if (en && g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      for (int i = 0; i < NR; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) dut_grants.push_back(i);
      end
      // Apply the coming clock edge to the model.
      if (en) begin
         if (exp_rv) void'(ages.pop_front());
         for (int j = 0; j < ages.size(); j++) ages[j] = ages[j] + 1;
         if (g >= 0) begin
            ages.push_back(1);
            pr    = longint'(pa[g]) * longint'($signed(pb[g]));
            r.p   = 32'(pr);
            r.id  = g;
            r.tag = pt[g];
            sb.push_back(r);
            rr      = (g + 1) % NR;
            pend[g] = 1'b0;
         end
      end
   endtask

   // Monitor: consume results from the scoreboard and check held outputs during stalls.
   initial begin
      logic          hold;
      logic [31:0]   hp;
      logic [IW-1:0] hid;
      logic [TW-1:0] htag;
      res_t          e;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("stall_res_p", bus.res_p, hp);
               chk("stall_res_id", bus.res_id, hid);
               chk("stall_res_tag", bus.res_tag, htag);
            end
            hold = 1'b0;
            if (bus.res_valid) begin
               if (bus.res_ready) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL spurious_result t=%0t actual=id%0d required=none", $time,
                              bus.res_id);
                  end else begin
                     e = sb.pop_front();
                     chk("res_p", bus.res_p, e.p);
                     chk("res_id", bus.res_id, e.id);
                     chk("res_tag", bus.res_tag, e.tag);
                  end
               end else begin
                  hold = 1'b1;
                  hp   = bus.res_p;
                  hid  = bus.res_id;
                  htag = bus.res_tag;
               end
            end
         end
      end
   end

   initial begin
      pend     = '0;
      rdy      = 1'b1;
      mode     = 0;
      fair_cnt = 0;
      rst_cmd  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         pa[i] = '0;
         pb[i] = '0;
         pt[i] = '0;
      end
      drive();
      #2 rst_n = 1'b0;
      repeat (3) step();

      // Single request from requester 2.
      rst_cmd = 1'b1;
      issue(2, 16'd3, 16'hFFFB, 8'h11);
      repeat (5) step();
      chk_grant("single_grant", 0, 2);

      // Extreme operands.
      issue(0, 16'hFFFF, 16'h7FFF, 8'h21);
      issue(1, 16'hFFFF, 16'h8000, 8'h22);
      issue(3, 16'h0000, 16'hFFFF, 8'h23);
      repeat (8) step();

      // Backpressure: four requests, stall three cycles once the first result shows.
      for (int i = 0; i < NR; i++) issue_rnd(i);
      repeat (2) step();
      rdy = 1'b0;
      repeat (3) step();
      rdy = 1'b1;
      repeat (8) step();

      // Reset with two entries in flight.
      issue(0, 16'd100, 16'd7, 8'h31);
      issue(2, 16'd200, 16'hFFF0, 8'h32);
      repeat (2) step();
      rst_cmd = 1'b0;
      repeat (2) step();
      rst_cmd = 1'b1;
      issue(1, 16'd9, 16'd9, 8'h41);
      issue(3, 16'd5, 16'hFFFF, 8'h42);
      repeat (6) step();
      chk_grant("post_reset_grant", 0, 1);
      chk_grant("post_reset_grant2", 1, 3);

      // Full contention from reset.
      rst_cmd = 1'b0;
      repeat (2) step();
      mode    = 2;
      rst_cmd = 1'b1;
      repeat (12) step();
      for (int k = 0; k < 8; k++) chk_grant("contention_grant", k, k % NR);
      mode = 0;
      repeat (8) step();

      // Fairness: requester 0 always valid, requester 3 joins after five cycles.
      rst_cmd = 1'b0;
      repeat (2) step();
      mode     = 3;
      fair_cnt = 0;
      rst_cmd  = 1'b1;
      repeat (14) step();
      for (int k = 0; k < 14; k++) chk_grant("fair_grant", k, (k >= 5 && k % 2 == 1) ? 3 : 0);
      mode = 0;
      pend = '0;
      repeat (4) step();

      // Randomized traffic with random backpressure and request drops.
      mode = 1;
      repeat (3000) step();
      mode = 0;
      rdy  = 1'b1;
      pend = '0;
      repeat (10) step();
      chk("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
